fifo_ptr_flag: RTL and testbench
================================

// Module: fifo_ptr_flag
// PURPOSE
//  Parametrised gray-code pointer and flag generator for one side of the async FIFO.
//  Keeps an (ADDR_WIDTH+1)-bit binary/gray pointer with a wrap bit and a 2..N-flop
//  synchroniser for the opposite side's gray pointer. Produces full (MODE=0, write
//  side) or empty (MODE=1, read side), plus almost flag, level and sticky error.
//  One instance sits in each clock domain; they cross-connect gray pointers.
// PARAMETERS
//  ADDR_WIDTH   4  RAM address bits; depth = 2**ADDR_WIDTH, pointer = ADDR_WIDTH+1 bits
//  SYNC_STAGES  2  flops in other_gray_in synchroniser (legal >= 2)
//  MODE         0  0 = write side (full/almost-full), 1 = read side (empty/almost-empty)
//  ALMOST_TH    2  almost threshold in entries (legal 1 .. depth-1)
// PORTS
//  clk            in   1             block clock, rising edge
//  rst_in         in   1             asynchronous, active-high reset
//  clr_in         in   1             synchronous clear of pointer, flags, error
//  inc_in         in   1             advance request (write or read strobe)
//  other_gray_in  in   ADDR_WIDTH+1  opposite-domain gray pointer (async to clk)
//  ptr_gray_out   out  ADDR_WIDTH+1  registered gray pointer, to opposite domain
//  addr_out       out  ADDR_WIDTH    RAM address = binary pointer low bits
//  flag_out       out  1             MODE0: full; MODE1: empty
//  almost_out     out  1             MODE0: level >= depth-ALMOST_TH; MODE1: level <= ALMOST_TH
//  level_out      out  ADDR_WIDTH+1  occupancy as seen from this side, 0..depth
//  err_out        out  1             sticky: inc_in while flag_out=1 (over/underflow)
// BEHAVIOUR
//  - Priority: rst_in > clr_in > inc_in. Reset: bin/gray/addr/level/err = 0,
//    synchroniser = 0, flag_out = MODE (0 not full / 1 empty), almost_out = MODE.
//    rst_in takes effect immediately; no clock needed.
//  - clr_in: same values as reset on next edge, synchroniser NOT cleared.
//  - Accepted advance = inc_in & ~flag_out: bin_next = bin+1 (mod 2**(ADDR_WIDTH+1)).
//    Rejected (inc_in & flag_out): pointer holds, err_out <= 1 until rst/clr.
//  - gray = bin_next ^ (bin_next>>1), registered directly; ptr_gray_out changes
//    exactly one bit per accepted advance, never glitches, wraps gray 10..0 -> 00..0.
//  - sync_gray = last stage of synchroniser; other-side change visible after
//    SYNC_STAGES edges; flags are pessimistic only (never falsely not-full/not-empty).
//  - All flags use next-state pointer and current sync_gray, registered on same
//    edge as pointer (zero-cycle flag lag on own side):
//    full  = gray_next == {~sync_gray[MSB:MSB-1], sync_gray[MSB-2:0]}
//    empty = gray_next == sync_gray
//  - sync_bin = gray2bin(sync_gray) (prefix XOR from MSB).
//    MODE0 level = bin_next - sync_bin; MODE1 level = sync_bin - bin_next; mod 2**(A+1).
//  - Same-cycle accepted advance and other-pointer movement: both used; no stall.
//  - ADDR_WIDTH=1 legal (full compare uses both pointer bits inverted).
// STRUCTURE
//  - Package fifo_ptr_pkg: MODE_WR/MODE_RD constants, bin2gray/gray2bin functions.
//  - Sub-module gray_sync: SYNC_STAGES-deep flop chain, async reset to 0, width param.
//  - Top: pointer regs, flag/level/almost logic, error latch. No other submodules.
// TESTING (ADDR_WIDTH=2, SYNC_STAGES=2, ALMOST_TH=1 unless noted)
//  1 MODE0, other_gray_in=000: 4 incs -> gray 001,011,010,110; full=1 after 4th,
//    level=4, almost=1 after 3rd; 5th inc -> gray stays 110, err_out=1.
//  2 MODE1, other_gray_in 000->011 (bin 2): empty drops 2 edges later, level=2;
//    2 incs -> empty=1 on 2nd edge, addr 0,1; 3rd inc -> err_out=1, ptr holds 011.
//  3 MODE0 with other_gray_in tracking own ptr 3 edges late, 10 incs -> bin wraps
//    111->000, gray 100->000, full never asserts, one bit change per advance.
//  4 rst_in pulsed between edges mid-stream -> all outputs reset at once, MODE1 empty=1.
//  5 clr_in and inc_in same cycle -> pointer 0, err_out 0, synchroniser unchanged.
//  6 ADDR_WIDTH=4, SYNC_STAGES=3, MODE0: fill 16 -> full at 16, err on 17th.

Source files
------------

// File: rtl/fifo_ptr_pkg.sv
// Shared constants and gray/binary conversion helpers for the async FIFO pointer blocks.
// Conversions work on a 32-bit container; callers zero-extend and truncate with size casts.
package fifo_ptr_pkg;

  localparam int MODE_WR = 0;
  localparam int MODE_RD = 1;
  localparam int CONV_W  = 32;

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of its gray bit and every gray bit above it.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
    logic [CONV_W-1:0] bin;
    bin = gray;
    for (int i = 1; i < CONV_W; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for the opposite clock domain's gray pointer.
// Only one bit of the input changes at a time, so a plain flop chain is safe.
module gray_sync
  import fifo_ptr_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_in};
    end
  end

  assign q_out = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_ptr_flag.sv
// One side of an async FIFO: binary/gray pointer, synchronised opposite pointer,
// full (write side) or empty (read side) flag, almost flag, occupancy level and sticky error.
module fifo_ptr_flag
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int ALMOST_TH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  clr_in,
  input  logic                  inc_in,
  input  logic [ADDR_WIDTH:0]   other_gray_in,
  output logic [ADDR_WIDTH:0]   ptr_gray_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  flag_out,
  output logic                  almost_out,
  output logic [ADDR_WIDTH:0]   level_out,
  output logic                  err_out
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Full compares against the other pointer with its top two gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK        = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] ALMOST_FULL_LVL  = PW'(DEPTH - ALMOST_TH);
  localparam logic [PW-1:0] ALMOST_EMPTY_LVL = PW'(ALMOST_TH);
  localparam logic          IDLE_FLAG        = (MODE == MODE_RD);

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          flag_q, flag_d;
  logic          almost_q, almost_d;
  logic          err_q, err_d;

  logic [PW-1:0] syncGray;
  logic [PW-1:0] syncBin;
  logic          accept;

  gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_gray_sync (
    .clk    (clk),
    .rst_in (rst_in),
    .d_in   (other_gray_in),
    .q_out  (syncGray)
  );

  // Flags and level come from the next pointer value so this side never lags itself.
  always_comb begin
    accept   = inc_in & ~flag_q;
    bin_d    = accept ? bin_q + PW'(1) : bin_q;
    gray_d   = PW'(bin2gray(CONV_W'(bin_d)));
    syncBin  = PW'(gray2bin(CONV_W'(syncGray)));
    level_d  = '0;
    flag_d   = IDLE_FLAG;
    almost_d = IDLE_FLAG;
    if (MODE == MODE_WR) begin
      level_d  = bin_d - syncBin;
      flag_d   = (gray_d == (syncGray ^ FULL_MASK));
      almost_d = (level_d >= ALMOST_FULL_LVL);
    end else begin
      level_d  = syncBin - bin_d;
      flag_d   = (gray_d == syncGray);
      almost_d = (level_d <= ALMOST_EMPTY_LVL);
    end
    err_d = err_q | (inc_in & flag_q);
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      bin_q    <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      flag_q   <= IDLE_FLAG;
      almost_q <= IDLE_FLAG;
      err_q    <= 1'b0;
    end else if (clr_in) begin
      bin_q    <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      flag_q   <= IDLE_FLAG;
      almost_q <= IDLE_FLAG;
      err_q    <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      flag_q   <= flag_d;
      almost_q <= almost_d;
      err_q    <= err_d;
    end
  end

  assign ptr_gray_out = gray_q;
  assign addr_out     = bin_q[ADDR_WIDTH-1:0];
  assign flag_out     = flag_q;
  assign almost_out   = almost_q;
  assign level_out    = level_q;
  assign err_out      = err_q;

endmodule

// File: tb/tb_fifo_ptr_flag.sv
// Directed bench for fifo_ptr_flag: small write/read sides plus a deeper write side.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_fifo_ptr_flag;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // u0: MODE0, A=2 | u1: MODE1, A=2 | u2: MODE0, A=4, S=3
  logic       rst0, clr0, inc0, flag0, almost0, err0;
  logic [2:0] other0, gray0, level0;
  logic [1:0] addr0;
  logic       rst1, clr1, inc1, flag1, almost1, err1;
  logic [2:0] other1, gray1, level1;
  logic [1:0] addr1;
  logic       rst2, clr2, inc2, flag2, almost2, err2;
  logic [4:0] other2, gray2, level2;
  logic [3:0] addr2;

  fifo_ptr_flag #(.ADDR_WIDTH(2), .SYNC_STAGES(2), .MODE(0), .ALMOST_TH(1)) u0 (
    .clk(clk), .rst_in(rst0), .clr_in(clr0), .inc_in(inc0), .other_gray_in(other0),
    .ptr_gray_out(gray0), .addr_out(addr0), .flag_out(flag0), .almost_out(almost0),
    .level_out(level0), .err_out(err0));

  fifo_ptr_flag #(.ADDR_WIDTH(2), .SYNC_STAGES(2), .MODE(1), .ALMOST_TH(1)) u1 (
    .clk(clk), .rst_in(rst1), .clr_in(clr1), .inc_in(inc1), .other_gray_in(other1),
    .ptr_gray_out(gray1), .addr_out(addr1), .flag_out(flag1), .almost_out(almost1),
    .level_out(level1), .err_out(err1));

  fifo_ptr_flag #(.ADDR_WIDTH(4), .SYNC_STAGES(3), .MODE(0), .ALMOST_TH(2)) u2 (
    .clk(clk), .rst_in(rst2), .clr_in(clr2), .inc_in(inc2), .other_gray_in(other2),
    .ptr_gray_out(gray2), .addr_out(addr2), .flag_out(flag2), .almost_out(almost2),
    .level_out(level2), .err_out(err2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    inc0 = 1'b0; inc1 = 1'b0; inc2 = 1'b0;
    other0 = '0; other1 = '0; other2 = '0;
    #2;
    testsRun++;
    if ({gray0, addr0, level0, flag0, almost0, err0} !== 11'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_u0: got %b expected %b", {gray0, addr0, level0, flag0, almost0, err0}, 11'b0);
    end
    testsRun++;
    if ({gray1, addr1, level1, flag1, almost1, err1} !== 11'b00000000110) begin
      testsFailed++;
      $display("[TB] FAIL reset_u1: got %b expected %b", {gray1, addr1, level1, flag1, almost1, err1}, 11'b00000000110);
    end
    testsRun++;
    if ({gray2, level2, flag2, almost2, err2} !== 13'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_u2: got %b expected %b", {gray2, level2, flag2, almost2, err2}, 13'b0);
    end
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_fill_wr();
    logic [2:0] expGray  [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
    logic [2:0] expLevel [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [1:0] expAddr  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic       expAlm   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       expFull  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tick();
    for (int i = 0; i < 4; i++) begin
      inc0 = 1'b1;
      tick();
      testsRun++;
      if ({gray0, level0, addr0, almost0, flag0, err0} !== {expGray[i], expLevel[i], expAddr[i], expAlm[i], expFull[i], 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL fill_wr_inc%0d: got gray=%b lvl=%0d addr=%0d alm=%b full=%b err=%b expected gray=%b lvl=%0d addr=%0d alm=%b full=%b err=0",
                 i + 1, gray0, level0, addr0, almost0, flag0, err0, expGray[i], expLevel[i], expAddr[i], expAlm[i], expFull[i]);
      end
    end
    tick();
    inc0 = 1'b0;
    testsRun++;
    if ({gray0, level0, flag0, err0} !== {3'b110, 3'd4, 1'b1, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL fill_wr_overflow: got gray=%b lvl=%0d full=%b err=%b expected gray=110 lvl=4 full=1 err=1",
               gray0, level0, flag0, err0);
    end
  endtask

  task automatic test_drain_rd();
    other1 = 3'b011;
    tick();
    testsRun++;
    if (flag1 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rd_empty_early: got %b expected 1", flag1);
    end
    tick();
    tick();
    testsRun++;
    if ({flag1, level1, almost1, addr1} !== {1'b0, 3'd2, 1'b0, 2'd0}) begin
      testsFailed++;
      $display("[TB] FAIL rd_not_empty: got empty=%b lvl=%0d alm=%b addr=%0d expected empty=0 lvl=2 alm=0 addr=0",
               flag1, level1, almost1, addr1);
    end
    inc1 = 1'b1;
    tick();
    testsRun++;
    if ({flag1, level1, almost1, addr1, gray1} !== {1'b0, 3'd1, 1'b1, 2'd1, 3'b001}) begin
      testsFailed++;
      $display("[TB] FAIL rd_inc1: got empty=%b lvl=%0d alm=%b addr=%0d gray=%b expected empty=0 lvl=1 alm=1 addr=1 gray=001",
               flag1, level1, almost1, addr1, gray1);
    end
    tick();
    testsRun++;
    if ({flag1, level1, gray1, err1} !== {1'b1, 3'd0, 3'b011, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL rd_inc2: got empty=%b lvl=%0d gray=%b err=%b expected empty=1 lvl=0 gray=011 err=0",
               flag1, level1, gray1, err1);
    end
    tick();
    inc1 = 1'b0;
    testsRun++;
    if ({err1, gray1, flag1} !== {1'b1, 3'b011, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL rd_underflow: got err=%b gray=%b empty=%b expected err=1 gray=011 empty=1", err1, gray1, flag1);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst1 = 1'b1;
    #1;
    testsRun++;
    if ({gray1, addr1, level1, flag1, almost1, err1} !== 11'b00000000110) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_u1: got %b expected %b", {gray1, addr1, level1, flag1, almost1, err1}, 11'b00000000110);
    end
    #1;
    rst1 = 1'b0;
    tick();
  endtask

  task automatic test_clear_with_inc();
    tick();
    tick();
    testsRun++;
    if ({flag1, level1} !== {1'b0, 3'd2}) begin
      testsFailed++;
      $display("[TB] FAIL clr_pre_rd: got empty=%b lvl=%0d expected empty=0 lvl=2", flag1, level1);
    end
    clr0 = 1'b1; inc0 = 1'b1;
    clr1 = 1'b1; inc1 = 1'b1;
    tick();
    clr0 = 1'b0; inc0 = 1'b0;
    clr1 = 1'b0; inc1 = 1'b0;
    testsRun++;
    if ({gray0, addr0, level0, flag0, almost0, err0} !== 11'b0) begin
      testsFailed++;
      $display("[TB] FAIL clr_wr: got %b expected %b", {gray0, addr0, level0, flag0, almost0, err0}, 11'b0);
    end
    testsRun++;
    if ({gray1, level1, flag1, err1} !== {3'b000, 3'd0, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL clr_rd: got gray=%b lvl=%0d empty=%b err=%b expected gray=000 lvl=0 empty=1 err=0",
               gray1, level1, flag1, err1);
    end
    tick();
    testsRun++;
    if ({flag1, level1} !== {1'b0, 3'd2}) begin
      testsFailed++;
      $display("[TB] FAIL clr_sync_kept: got empty=%b lvl=%0d expected empty=0 lvl=2", flag1, level1);
    end
  endtask

  task automatic test_wrap_tracking();
    logic [2:0] hist [$];
    logic [2:0] model;
    logic [2:0] prevGray;
    logic       didInc;
    model    = 3'd0;
    prevGray = gray0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      didInc = (cyc % 2 == 0);
      inc0   = didInc;
      tick();
      if (didInc) model = model + 3'd1;
      testsRun++;
      if (gray0 !== (model ^ (model >> 1))) begin
        testsFailed++;
        $display("[TB] FAIL wrap_gray_c%0d: got %b expected %b", cyc, gray0, model ^ (model >> 1));
      end
      testsRun++;
      if ($countones(gray0 ^ prevGray) !== (didInc ? 1 : 0)) begin
        testsFailed++;
        $display("[TB] FAIL wrap_onebit_c%0d: got %b->%b expected %0d bit change", cyc, prevGray, gray0, didInc ? 1 : 0);
      end
      testsRun++;
      if (flag0 !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL wrap_no_full_c%0d: got %b expected 0", cyc, flag0);
      end
      prevGray = gray0;
      hist.push_back(gray0);
      other0 = (hist.size() > 3) ? hist[hist.size() - 4] : 3'b000;
    end
    inc0 = 1'b0;
    testsRun++;
    if ({addr0, err0} !== {2'd2, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL wrap_end: got addr=%0d err=%b expected addr=2 err=0", addr0, err0);
    end
  endtask

  task automatic test_deep_fill();
    for (int i = 1; i <= 16; i++) begin
      inc2 = 1'b1;
      tick();
      testsRun++;
      if ({flag2, almost2, level2, err2} !== {(i == 16), (i >= 14), 5'(i), 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL deep_inc%0d: got full=%b alm=%b lvl=%0d err=%b expected full=%b alm=%b lvl=%0d err=0",
                 i, flag2, almost2, level2, err2, (i == 16), (i >= 14), i);
      end
    end
    tick();
    inc2 = 1'b0;
    testsRun++;
    if ({gray2, addr2, flag2, err2} !== {5'b11000, 4'd0, 1'b1, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL deep_overflow: got gray=%b addr=%0d full=%b err=%b expected gray=11000 addr=0 full=1 err=1",
               gray2, addr2, flag2, err2);
    end
  endtask

  initial begin
    test_reset();
    test_fill_wr();
    test_drain_rd();
    test_async_reset();
    test_clear_with_inc();
    test_wrap_tracking();
    test_deep_fill();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
